// File: rtl/dds_dac_pkg.sv
// Shared types and constants for the DDS-to-DAC SPI serialiser.
// The optional DAC_CHG_ONLY_EN build macro is handled in dds_dac_spi_tx.sv.
package dds_dac_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} dac_state_t;

  localparam int FRAME_W = 16;

  localparam logic [3:0] DAC_CTRL_FAST = 4'b1100;
  localparam logic [3:0] DAC_CTRL_SLOW = 4'b0100;

endpackage

// File: rtl/dds_dac_spi_tx_if.sv
// Sample handshake plus the DAC SPI pins, bundled for the serialiser.
// The master side feeds samples and watches the SPI pins; the slave side is the serialiser.
interface dds_dac_spi_tx_if #(
  parameter int DATA_W = 12
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              dac_sclk;
  logic              dac_cs_n;
  logic              dac_din;
  logic              frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, dac_sclk, dac_cs_n, dac_din, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dac_sclk, dac_cs_n, dac_din, frame_done
  );

endinterface

// File: rtl/dac_sclk_div.sv
// SCLK generator for the DAC serialiser: divides clk by CLK_DIV per half-period,
// produces one-cycle rise/fall enables and the registered SCLK level.
// It is held in reset (counter cleared, SCLK low) whenever i_enable is low.
module dac_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_riseTick,
  output logic o_fallTick,
  output logic o_sclk
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_halfDone;

  assign w_halfDone = i_enable && (r_cnt == CNT_W'(CLK_DIV - 1));
  assign o_riseTick = w_halfDone && !r_sclk;
  assign o_fallTick = w_halfDone && r_sclk;
  assign o_sclk     = r_sclk;

  // Count out each half-period and toggle SCLK at its end; idle low when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_enable) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_halfDone) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dds_dac_spi_tx.sv
// Serialises DDS samples into {CTRL_NIBBLE, sample} SPI frames for an external DAC,
// MSB first, framed by CS_n, with a valid/ready sample handshake.
// Build option: define DAC_CHG_ONLY_EN to skip frames whose sample equals the last one sent.
module dds_dac_spi_tx
  import dds_dac_pkg::*;
#(
  parameter int         DATA_W      = 12,
  parameter int         CLK_DIV     = 4,
  parameter int         CS_GAP      = 2,
  parameter logic [3:0] CTRL_NIBBLE = DAC_CTRL_FAST
) (
  input  logic             clk,
  input  logic             rst_n,
  dds_dac_spi_tx_if.slave  bus
);

  localparam int SHIFT_W = DATA_W + 4;
  localparam int GAP_W   = $clog2(CS_GAP + 1);

  dac_state_t         r_state;
  logic [SHIFT_W-1:0] r_shreg;
  logic [3:0]         r_bitCnt;
  logic               r_lastBit;
  logic [GAP_W-1:0]   r_gapCnt;
  logic               r_csN;
  logic               r_dinReady;
  logic               r_frameDone;

  logic w_riseTick;
  logic w_fallTick;
  logic w_sclk;
  logic w_accept;
  logic w_sendFrame;

  assign w_accept = (r_state == IDLE) && r_dinReady && bus.din_valid;

  dac_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclkDiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enable   (r_state == SHIFT),
    .o_riseTick (w_riseTick),
    .o_fallTick (w_fallTick),
    .o_sclk     (w_sclk)
  );

`ifdef DAC_CHG_ONLY_EN
  logic [DATA_W-1:0] r_lastSent;
  logic              r_haveSent;

  assign w_sendFrame = !r_haveSent || (bus.din != r_lastSent);

  // Remember the last sample that went out so repeats can be swallowed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastSent <= '0;
      r_haveSent <= 1'b0;
    end else if (w_accept && w_sendFrame) begin
      r_lastSent <= bus.din;
      r_haveSent <= 1'b1;
    end
  end
`else
  assign w_sendFrame = 1'b1;
`endif

  // Frame sequencer: accept in IDLE, shift on SCLK falls, hold CS_n high for the gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bitCnt    <= '0;
      r_lastBit   <= 1'b0;
      r_gapCnt    <= '0;
      r_csN       <= 1'b1;
      r_dinReady  <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        IDLE: begin
          r_dinReady <= 1'b1;
          if (w_accept && w_sendFrame) begin
            r_shreg    <= {CTRL_NIBBLE, bus.din};
            r_bitCnt   <= '0;
            r_lastBit  <= 1'b0;
            r_csN      <= 1'b0;
            r_dinReady <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_riseTick && (r_bitCnt == 4'(SHIFT_W - 1))) begin
            r_lastBit <= 1'b1;
          end
          if (w_fallTick) begin
            if (r_lastBit) begin
              r_shreg     <= '0;
              r_csN       <= 1'b1;
              r_frameDone <= 1'b1;
              r_gapCnt    <= '0;
              r_state     <= GAP;
            end else begin
              r_shreg  <= {r_shreg[SHIFT_W-2:0], 1'b0};
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (r_gapCnt == GAP_W'(CS_GAP - 1)) begin
            r_dinReady <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.din_ready  = r_dinReady;
  assign bus.dac_sclk   = w_sclk;
  assign bus.dac_cs_n   = r_csN;
  assign bus.dac_din    = r_shreg[SHIFT_W-1];
  assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_dds_dac_spi_tx.sv
// Self-checking bench for dds_dac_spi_tx (CLK_DIV=2, CS_GAP=2, fast control nibble).
// The DAC_CHG_ONLY_EN sequence is compiled in only when that macro is defined.
module tb_dds_dac_spi_tx;
  import dds_dac_pkg::*;

  localparam int         DATA_W     = 12;
  localparam int         CLK_DIV    = 2;
  localparam int         CS_GAP     = 2;
  localparam logic [3:0] CTRL       = DAC_CTRL_FAST;
  localparam int         CS_LOW     = 32 * CLK_DIV;
  localparam int         PERIOD     = 1 + CS_LOW + CS_GAP;
  localparam int         WAIT_LIMIT = 4 * PERIOD;

  typedef struct {
    logic [DATA_W-1:0] sample;
    logic [15:0]       frame;
  } vector_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  int          cycle = 0;
  logic        prevCs = 1'b1;
  logic        prevSclk = 1'b0;
  logic        prevDin = 1'b0;
  logic [15:0] capBits = '0;
  int          capN = 0;
  int          lowCount = 0;
  int          frameCount = 0;
  int          doneCount = 0;
  logic [15:0] lastFrame = '0;
  logic [15:0] expQ[$];
  int          acceptQ[$];
  int          acceptHist[$];
`ifdef DAC_CHG_ONLY_EN
  logic              modelHaveLast = 1'b0;
  logic [DATA_W-1:0] modelLast = '0;
`endif

  dds_dac_spi_tx_if #(.DATA_W(DATA_W)) bus ();

  dds_dac_spi_tx #(
    .DATA_W      (DATA_W),
    .CLK_DIV     (CLK_DIV),
    .CS_GAP      (CS_GAP),
    .CTRL_NIBBLE (CTRL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Reference behaviour of one accepted sample: a frame {CTRL, sample}, or none for a repeat
  task automatic modelAccept(input logic [DATA_W-1:0] d);
    bit sends;
    sends = 1'b1;
`ifdef DAC_CHG_ONLY_EN
    if (modelHaveLast && (d == modelLast)) sends = 1'b0;
    modelHaveLast = 1'b1;
    modelLast     = d;
`endif
    acceptHist.push_back(cycle);
    if (sends) begin
      expQ.push_back({CTRL, d});
      acceptQ.push_back(cycle);
    end
  endtask

  function automatic logic [DATA_W-1:0] sineSample(input int ph);
    real a;
    a = 2.0 * 3.14159265358979 * real'(ph % 4096) / 4096.0;
    return DATA_W'($rtoi(2047.5 + 2047.0 * $sin(a)));
  endfunction

  // Watch the SPI pins on the falling clk edge, reassemble frames and score them
  always @(negedge clk) begin
    logic [15:0] expF;
    cycle++;
    if (!rst_n) begin
      capN = 0;
      lowCount = 0;
      prevCs = 1'b1;
      prevSclk = 1'b0;
      expQ.delete();
      acceptQ.delete();
`ifdef DAC_CHG_ONLY_EN
      modelHaveLast = 1'b0;
`endif
    end else begin
      if (bus.din_valid && bus.din_ready) modelAccept(bus.din);
      if (!bus.dac_cs_n) begin
        if (prevCs) begin
          if (acceptQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedStart: cs_n fell at cycle %0d, required no frame", cycle);
          end else begin
            checkOutput("csLowStart", 32'(cycle - acceptQ.pop_front()), 1);
          end
        end
        lowCount++;
        if (bus.dac_sclk && !prevSclk) begin
          capBits = {capBits[14:0], bus.dac_din};
          capN++;
        end
        if (bus.dac_sclk && prevSclk) checkOutput("dinStableHigh", bus.dac_din, prevDin);
      end else if (!prevCs) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedFrame: got %h, required none", capBits);
        end else begin
          expF = expQ.pop_front();
          checkOutput("frameBits", capBits, expF);
        end
        checkOutput("bitCount", capN, 16);
        checkOutput("csLowCycles", lowCount, CS_LOW);
        checkOutput("frameDoneAtCsRise", bus.frame_done, 1);
        lastFrame = capBits;
        frameCount++;
        capN = 0;
        lowCount = 0;
      end
      if (bus.frame_done) doneCount++;
      prevCs   = bus.dac_cs_n;
      prevSclk = bus.dac_sclk;
      prevDin  = bus.dac_din;
    end
  end

  // Wait for din_ready, then present one sample with a single-cycle valid pulse
  task automatic applyStimulus(input logic [DATA_W-1:0] sample);
    int waited = 0;
    @(posedge clk); #1;
    while (!bus.din_ready && waited < WAIT_LIMIT) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.din_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout: din_ready=%b, required 1 within %0d cycles", bus.din_ready, WAIT_LIMIT);
    end else begin
      bus.din = sample;
      bus.din_valid = 1'b1;
      @(posedge clk); #1;
      bus.din_valid = 1'b0;
    end
  endtask

  task automatic waitFrames(input int target);
    int waited = 0;
    while (frameCount < target && waited < WAIT_LIMIT) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (frameCount < target) begin
      errors++;
      $display("[TB] FAIL frameTimeout: got %0d frames, required %0d", frameCount, target);
    end
  endtask

  // Hard stop in case the bench itself wedges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vector_t           vecs[5];
    int                base;
    int                doneBase;
    int                n;
    int                histStart;
    int                phase;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] prevS;

    vecs[0] = '{12'hA5C, 16'hCA5C};
    vecs[1] = '{12'h000, 16'hC000};
    vecs[2] = '{12'hFFF, 16'hCFFF};
    vecs[3] = '{12'h001, 16'hC001};
    vecs[4] = '{12'h800, 16'hC800};

    bus.din = '0;
    bus.din_valid = 1'b0;

    $display("[TB] reset and idle levels");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("resetCsN", bus.dac_cs_n, 1);
    checkOutput("resetSclk", bus.dac_sclk, 0);
    checkOutput("resetDin", bus.dac_din, 0);
    checkOutput("resetReady", bus.din_ready, 0);
    checkOutput("resetDone", bus.frame_done, 0);
    #198;
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("readyBeforeFirstEdge", bus.din_ready, 0);
    @(posedge clk); #1;
    checkOutput("readyAfterRelease", bus.din_ready, 1);

    $display("[TB] table-driven single frames");
    for (int i = 0; i < 5; i++) begin
      base = frameCount;
      applyStimulus(vecs[i].sample);
      n = 0;
      while (!bus.din_ready && n < WAIT_LIMIT) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("acceptToAcceptEdges", n + 1, PERIOD);
      waitFrames(base + 1);
      checkOutput("tableFrame", lastFrame, vecs[i].frame);
    end

    $display("[TB] back-to-back frames from a DDS sine");
    base = frameCount;
    histStart = acceptHist.size();
    phase = 0;
    bus.din_valid = 1'b1;
    repeat (5 * PERIOD + 2) begin
      bus.din = sineSample(phase + 256);
      phase++;
      @(posedge clk); #1;
    end
    bus.din_valid = 1'b0;
    checkOutput("b2bAccepts", acceptHist.size() - histStart, 6);
    waitFrames(base + (acceptHist.size() - histStart));
    for (int k = histStart + 1; k < acceptHist.size(); k++) begin
      checkOutput("b2bSpacing", acceptHist[k] - acceptHist[k-1], PERIOD);
    end

    $display("[TB] reset in the middle of a frame");
    base = frameCount;
    doneBase = doneCount;
    applyStimulus(12'h3C7);
    n = 0;
    while (capN < 7 && n < WAIT_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reachedBit7", capN, 7);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortCsN", bus.dac_cs_n, 1);
    checkOutput("abortSclk", bus.dac_sclk, 0);
    checkOutput("abortReady", bus.din_ready, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abortNoFrame", frameCount, base);
    checkOutput("abortNoDone", doneCount, doneBase);
    applyStimulus(12'h5E1);
    waitFrames(base + 1);
    checkOutput("postResetFrame", lastFrame, 16'hC5E1);

`ifdef DAC_CHG_ONLY_EN
    $display("[TB] repeated samples are swallowed");
    base = frameCount;
    applyStimulus(12'h800);
    waitFrames(base + 1);
    applyStimulus(12'h800);
    checkOutput("chgOnlyReadyHeld", bus.din_ready, 1);
    applyStimulus(12'h801);
    waitFrames(base + 2);
    repeat (PERIOD) @(posedge clk);
    #1;
    checkOutput("chgOnlyFrames", frameCount - base, 2);
    checkOutput("chgOnlyLast", lastFrame, 16'hC801);
`endif

    $display("[TB] random samples with input noise during the frame");
    prevS = 12'h801;
    for (int i = 0; i < 8; i++) begin
      base = frameCount;
      do s = DATA_W'($urandom_range(0, 4095)); while (s == prevS);
      prevS = s;
      applyStimulus(s);
      bus.din_valid = 1'b1;
      repeat ($urandom_range(5, CS_LOW - 5)) begin
        bus.din = DATA_W'($urandom);
        @(posedge clk); #1;
      end
      bus.din_valid = 1'b0;
      waitFrames(base + 1);
      checkOutput("randFrame", lastFrame, {CTRL, s});
    end

    repeat (PERIOD) @(posedge clk);
    #1;
    checkOutput("doneMatchesFrames", doneCount, frameCount);
    checkOutput("pendingFrames", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
